// File: rtl/in_pcm_sched_pkg.sv
// Shared types and widths for the IN_PCM channel scheduler.
package in_pcm_sched_pkg;

    localparam int NCH_DEFAULT = 32;
    localparam int S_W         = 8;
    localparam int SE_W        = 15;
    localparam int D_W         = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_EXEC = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

endpackage

// File: rtl/in_pcm_sched_if.sv
// SE fetch and difference-output handshakes of the scheduler.
interface in_pcm_sched_if #(
    parameter int CHW = 5
);
    import in_pcm_sched_pkg::*;

    // Both handshakes complete on a cycle where the request/valid side is high and the
    // ack/ready side is high; the requester holds ch/data steady until then.
    logic            se_req;
    logic [CHW-1:0]  se_ch;
    logic            se_ack;
    logic [SE_W-1:0] se_data;
    logic            d_valid;
    logic [CHW-1:0]  d_ch;
    logic [D_W-1:0]  d_out;
    logic            d_ready;

    modport master (
        output se_req, se_ch, d_valid, d_ch, d_out,
        input  se_ack, se_data, d_ready
    );

    modport slave (
        input  se_req, se_ch, d_valid, d_ch, d_out,
        output se_ack, se_data, d_ready
    );

endinterface

// File: rtl/pcm_sample_bank.sv
// Double-buffered per-channel sample store: writes fill one bank while the frame reads the other.
module pcm_sample_bank
    import in_pcm_sched_pkg::*;
#(
    parameter int NCH = NCH_DEFAULT,
    parameter int CHW = 5
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic           i_wr_en,
    input  logic [CHW-1:0] i_wr_ch,
    input  logic [S_W-1:0] i_wr_data,
    input  logic           i_swap,
    input  logic [CHW-1:0] i_rd_ch,
    output logic [S_W-1:0] o_rd_data
);

    logic [S_W-1:0] r_bank [2][NCH];
    logic           r_wr_bank;
    logic           w_wr_ok;

    assign w_wr_ok = i_wr_en && (32'(i_wr_ch) < 32'(NCH));

    // A write coinciding with a swap uses the old r_wr_bank, so it joins the frame being started.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_bank <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int c = 0; c < NCH; c++) begin
                    r_bank[b][c] <= '0;
                end
            end
        end else begin
            if (w_wr_ok) begin
                r_bank[r_wr_bank][i_wr_ch] <= i_wr_data;
            end
            if (i_swap) begin
                r_wr_bank <= ~r_wr_bank;
            end
        end
    end

    assign o_rd_data = r_bank[~r_wr_bank][i_rd_ch];

endmodule

// File: rtl/in_pcm_sched.sv
// Time-multiplexes one IN_PCM datapath across NCH channels, one pass per frame strobe.
module in_pcm_sched
    import in_pcm_sched_pkg::*;
#(
    parameter int NCH = NCH_DEFAULT,
    parameter int CHW = $clog2(NCH)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_fs,
    input  logic             i_s_wr_en,
    input  logic [CHW-1:0]   i_s_wr_ch,
    input  logic [S_W-1:0]   i_s_wr_data,
    input  logic [NCH-1:0]   i_law_sel,
    input  logic [D_W-1:0]   i_pcm_d,
    input  logic             i_ovr_clr,
    output logic [S_W-1:0]   o_pcm_s,
    output logic             o_pcm_law,
    output logic [SE_W-1:0]  o_pcm_se,
    output logic             o_busy,
    output logic             o_frame_done,
    output logic             o_ovr,
    output state_t           o_state,
    in_pcm_sched_if.master   io_bus
);

    state_t          r_state;
    state_t          w_next;
    logic [CHW-1:0]  r_ch;
    logic [S_W-1:0]  r_pcm_s;
    logic            r_pcm_law;
    logic [SE_W-1:0] r_pcm_se;
    logic [D_W-1:0]  r_d_out;
    logic [CHW-1:0]  r_d_ch;
    logic            r_frame_done;
    logic            r_ovr;
    logic            w_swap;
    logic            w_ack;
    logic            w_take;
    logic            w_last;
    logic [S_W-1:0]  w_rd_data;

    pcm_sample_bank #(
        .NCH (NCH),
        .CHW (CHW)
    ) u_bank (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_wr_en   (i_s_wr_en),
        .i_wr_ch   (i_s_wr_ch),
        .i_wr_data (i_s_wr_data),
        .i_swap    (w_swap),
        .i_rd_ch   (r_ch),
        .o_rd_data (w_rd_data)
    );

    assign w_last = (r_ch == CHW'(NCH - 1));

    always_comb begin
        w_next = r_state;
        w_swap = 1'b0;
        w_ack  = 1'b0;
        w_take = 1'b0;
        case (r_state)
            ST_IDLE: if (i_fs) begin
                w_next = ST_REQ;
                w_swap = 1'b1;
            end
            ST_REQ: if (io_bus.se_ack) begin
                w_next = ST_EXEC;
                w_ack  = 1'b1;
            end
            ST_EXEC: w_next = ST_OUT;
            ST_OUT: if (io_bus.d_ready) begin
                w_take = 1'b1;
                w_next = w_last ? ST_IDLE : ST_REQ;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_ch         <= '0;
            r_pcm_s      <= '0;
            r_pcm_law    <= 1'b0;
            r_pcm_se     <= '0;
            r_d_out      <= '0;
            r_d_ch       <= '0;
            r_frame_done <= 1'b0;
            r_ovr        <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_frame_done <= w_take && w_last;
            if (w_swap) begin
                r_ch <= '0;
            end else if (w_take && !w_last) begin
                r_ch <= r_ch + 1'b1;
            end
            if (w_ack) begin
                r_pcm_se  <= io_bus.se_data;
                r_pcm_s   <= w_rd_data;
                r_pcm_law <= i_law_sel[r_ch];
            end
            // IN_PCM is combinational, so D is valid one cycle after its inputs load.
            if (r_state == ST_EXEC) begin
                r_d_out <= i_pcm_d;
                r_d_ch  <= r_ch;
            end
            if (i_fs && (r_state != ST_IDLE)) begin
                r_ovr <= 1'b1;
            end else if (i_ovr_clr) begin
                r_ovr <= 1'b0;
            end
        end
    end

    assign io_bus.se_req  = (r_state == ST_REQ);
    assign io_bus.se_ch   = r_ch;
    assign io_bus.d_valid = (r_state == ST_OUT);
    assign io_bus.d_ch    = r_d_ch;
    assign io_bus.d_out   = r_d_out;
    assign o_pcm_s        = r_pcm_s;
    assign o_pcm_law      = r_pcm_law;
    assign o_pcm_se       = r_pcm_se;
    assign o_busy         = (r_state != ST_IDLE);
    assign o_frame_done   = r_frame_done;
    assign o_ovr          = r_ovr;
    assign o_state        = r_state;

endmodule

// File: tb/tb_in_pcm_sched.sv
// Directed, table-driven bench for in_pcm_sched with NCH = 4.
module tb_in_pcm_sched;
    import in_pcm_sched_pkg::*;

    localparam int NCH = 4;
    localparam int CHW = 2;

    typedef struct {
        logic [7:0]  exp_s;
        logic        exp_law;
        logic [14:0] se;
        int          ack_dly;
        int          rdy_dly;
        bit          fs_in_req;
        bit          do_wr;
        logic [1:0]  wr_ch;
        logic [7:0]  wr_data;
    } vec_t;

    logic           clk = 1'b0;
    logic           reset;
    logic           fs;
    logic           s_wr_en;
    logic [CHW-1:0] s_wr_ch;
    logic [7:0]     s_wr_data;
    logic [NCH-1:0] law_sel;
    logic [15:0]    pcm_d;
    logic           ovr_clr;
    logic [7:0]     pcm_s;
    logic           pcm_law;
    logic [14:0]    pcm_se;
    logic           busy;
    logic           frame_done;
    logic           ovr;
    state_t         state;

    vec_t tbl [24];
    int   n_vec = 0;
    int   n_err = 0;

    in_pcm_sched_if #(.CHW(CHW)) bus ();

    in_pcm_sched #(
        .NCH (NCH),
        .CHW (CHW)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_fs         (fs),
        .i_s_wr_en    (s_wr_en),
        .i_s_wr_ch    (s_wr_ch),
        .i_s_wr_data  (s_wr_data),
        .i_law_sel    (law_sel),
        .i_pcm_d      (pcm_d),
        .i_ovr_clr    (ovr_clr),
        .o_pcm_s      (pcm_s),
        .o_pcm_law    (pcm_law),
        .o_pcm_se     (pcm_se),
        .o_busy       (busy),
        .o_frame_done (frame_done),
        .o_ovr        (ovr),
        .o_state      (state),
        .io_bus       (bus)
    );

    // Stand-in for the combinational IN_PCM: a fixed bit-packing of its three inputs.
    assign pcm_d = {pcm_s, pcm_law, pcm_se[6:0]};

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " se_req"}, 32'(bus.se_req), 0);
        check({tag, " se_ch"}, 32'(bus.se_ch), 0);
        check({tag, " pcm_s"}, 32'(pcm_s), 0);
        check({tag, " pcm_law"}, 32'(pcm_law), 0);
        check({tag, " pcm_se"}, 32'(pcm_se), 0);
        check({tag, " d_valid"}, 32'(bus.d_valid), 0);
        check({tag, " d_ch"}, 32'(bus.d_ch), 0);
        check({tag, " d_out"}, 32'(bus.d_out), 0);
        check({tag, " busy"}, 32'(busy), 0);
        check({tag, " frame_done"}, 32'(frame_done), 0);
        check({tag, " ovr"}, 32'(ovr), 0);
        check({tag, " state"}, 32'(state), 32'(ST_IDLE));
    endtask

    task automatic write_sample(input logic [1:0] ch, input logic [7:0] data);
        s_wr_en   = 1'b1;
        s_wr_ch   = ch;
        s_wr_data = data;
        tick();
        s_wr_en   = 1'b0;
    endtask

    task automatic start_frame(input bit wr, input logic [1:0] ch, input logic [7:0] data);
        fs        = 1'b1;
        s_wr_en   = wr;
        s_wr_ch   = ch;
        s_wr_data = data;
        tick();
        fs        = 1'b0;
        s_wr_en   = 1'b0;
    endtask

    // Entered on the cycle the channel's REQ is expected; leaves after the OUT accept.
    task automatic run_channel(input int i);
        vec_t        v;
        logic [1:0]  ch;
        logic [15:0] exp_d;
        v     = tbl[i];
        ch    = 2'(i % NCH);
        exp_d = {v.exp_s, v.exp_law, v.se[6:0]};
        check($sformatf("v%0d se_req", i), 32'(bus.se_req), 1);
        check($sformatf("v%0d se_ch", i), 32'(bus.se_ch), 32'(ch));
        check($sformatf("v%0d busy", i), 32'(busy), 1);
        if (v.do_wr) begin
            s_wr_en   = 1'b1;
            s_wr_ch   = v.wr_ch;
            s_wr_data = v.wr_data;
        end
        if (v.fs_in_req) fs = 1'b1;
        for (int k = 0; k < v.ack_dly; k++) begin
            tick();
            s_wr_en = 1'b0;
            fs      = 1'b0;
            check($sformatf("v%0d wait se_req", i), 32'(bus.se_req), 1);
            check($sformatf("v%0d wait se_ch", i), 32'(bus.se_ch), 32'(ch));
            check($sformatf("v%0d wait state", i), 32'(state), 32'(ST_REQ));
        end
        bus.se_ack  = 1'b1;
        bus.se_data = v.se;
        tick();
        bus.se_ack  = 1'b0;
        bus.se_data = ~v.se;
        s_wr_en     = 1'b0;
        fs          = 1'b0;
        check($sformatf("v%0d exec state", i), 32'(state), 32'(ST_EXEC));
        check($sformatf("v%0d exec se_req", i), 32'(bus.se_req), 0);
        check($sformatf("v%0d pcm_s", i), 32'(pcm_s), 32'(v.exp_s));
        check($sformatf("v%0d pcm_law", i), 32'(pcm_law), 32'(v.exp_law));
        check($sformatf("v%0d pcm_se", i), 32'(pcm_se), 32'(v.se));
        if (v.fs_in_req) check($sformatf("v%0d ovr", i), 32'(ovr), 1);
        tick();
        check($sformatf("v%0d d_valid", i), 32'(bus.d_valid), 1);
        check($sformatf("v%0d d_ch", i), 32'(bus.d_ch), 32'(ch));
        check($sformatf("v%0d d_out", i), 32'(bus.d_out), 32'(exp_d));
        for (int k = 0; k < v.rdy_dly; k++) begin
            tick();
            check($sformatf("v%0d hold d_valid", i), 32'(bus.d_valid), 1);
            check($sformatf("v%0d hold d_ch", i), 32'(bus.d_ch), 32'(ch));
            check($sformatf("v%0d hold d_out", i), 32'(bus.d_out), 32'(exp_d));
            check($sformatf("v%0d hold se_req", i), 32'(bus.se_req), 0);
        end
        bus.d_ready = 1'b1;
        tick();
        bus.d_ready = 1'b0;
    endtask

    task automatic run_frame(input int f);
        for (int c = 0; c < NCH; c++) begin
            run_channel(f * NCH + c);
        end
        check($sformatf("f%0d frame_done", f), 32'(frame_done), 1);
        check($sformatf("f%0d end state", f), 32'(state), 32'(ST_IDLE));
        check($sformatf("f%0d end busy", f), 32'(busy), 0);
        tick();
        check($sformatf("f%0d frame_done drop", f), 32'(frame_done), 0);
    endtask

    initial begin
        // exp_s, exp_law, se, ack_dly, rdy_dly, fs_in_req, do_wr, wr_ch, wr_data
        tbl[0]  = '{8'hD5, 1'b0, 15'h1201, 0, 0, 1'b0, 1'b0, 2'd0, 8'h00};
        tbl[1]  = '{8'hFF, 1'b1, 15'h2302, 0, 0, 1'b0, 1'b1, 2'd0, 8'h55};
        tbl[2]  = '{8'h80, 1'b0, 15'h3403, 0, 0, 1'b0, 1'b0, 2'd0, 8'h00};
        tbl[3]  = '{8'h80, 1'b1, 15'h7FFF, 0, 0, 1'b0, 1'b0, 2'd0, 8'h00};
        tbl[4]  = '{8'h55, 1'b0, 15'h0A5A, 0, 0, 1'b0, 1'b0, 2'd0, 8'h00};
        tbl[5]  = '{8'h00, 1'b1, 15'h0001, 0, 0, 1'b0, 1'b0, 2'd0, 8'h00};
        tbl[6]  = '{8'h00, 1'b0, 15'h4000, 0, 0, 1'b0, 1'b0, 2'd0, 8'h00};
        tbl[7]  = '{8'h00, 1'b1, 15'h1357, 0, 0, 1'b0, 1'b0, 2'd0, 8'h00};
        tbl[8]  = '{8'hD5, 1'b0, 15'h2468, 0, 0, 1'b0, 1'b0, 2'd0, 8'h00};
        tbl[9]  = '{8'hFF, 1'b1, 15'h7654, 0, 0, 1'b0, 1'b0, 2'd0, 8'h00};
        tbl[10] = '{8'h3C, 1'b0, 15'h0F0F, 0, 0, 1'b0, 1'b0, 2'd0, 8'h00};
        tbl[11] = '{8'h80, 1'b1, 15'h5555, 0, 0, 1'b0, 1'b0, 2'd0, 8'h00};
        tbl[12] = '{8'h55, 1'b0, 15'h1111, 5, 10, 1'b0, 1'b0, 2'd0, 8'h00};
        tbl[13] = '{8'h00, 1'b1, 15'h2222, 0, 0, 1'b0, 1'b0, 2'd0, 8'h00};
        tbl[14] = '{8'h00, 1'b0, 15'h3333, 0, 0, 1'b0, 1'b0, 2'd0, 8'h00};
        tbl[15] = '{8'h00, 1'b1, 15'h4444, 0, 0, 1'b1, 1'b0, 2'd0, 8'h00};
        tbl[16] = '{8'hD5, 1'b0, 15'h0123, 0, 0, 1'b0, 1'b0, 2'd0, 8'h00};
        tbl[17] = '{8'hFF, 1'b1, 15'h0456, 0, 0, 1'b0, 1'b0, 2'd0, 8'h00};
        tbl[18] = '{8'h3C, 1'b0, 15'h0789, 0, 0, 1'b0, 1'b0, 2'd0, 8'h00};
        tbl[19] = '{8'h80, 1'b1, 15'h0ABC, 0, 0, 1'b0, 1'b0, 2'd0, 8'h00};
        tbl[20] = '{8'h11, 1'b0, 15'h6001, 0, 0, 1'b0, 1'b0, 2'd0, 8'h00};
        tbl[21] = '{8'h00, 1'b1, 15'h6002, 0, 0, 1'b0, 1'b0, 2'd0, 8'h00};
        tbl[22] = '{8'h00, 1'b0, 15'h6003, 0, 0, 1'b0, 1'b0, 2'd0, 8'h00};
        tbl[23] = '{8'h00, 1'b1, 15'h6004, 0, 0, 1'b0, 1'b0, 2'd0, 8'h00};

        reset       = 1'b1;
        fs          = 1'b0;
        s_wr_en     = 1'b0;
        s_wr_ch     = '0;
        s_wr_data   = '0;
        law_sel     = 4'b1010;
        ovr_clr     = 1'b0;
        bus.se_ack  = 1'b0;
        bus.se_data = '0;
        bus.d_ready = 1'b0;
        repeat (3) tick();
        check_zero("reset");
        reset = 1'b0;

        // Stray ack/ready in IDLE must not move the FSM.
        bus.se_ack  = 1'b1;
        bus.d_ready = 1'b1;
        tick();
        bus.se_ack  = 1'b0;
        bus.d_ready = 1'b0;
        check("idle stray state", 32'(state), 32'(ST_IDLE));
        check("idle stray d_valid", 32'(bus.d_valid), 0);

        write_sample(2'd0, 8'hD5);
        write_sample(2'd1, 8'hFF);
        write_sample(2'd2, 8'h80);
        write_sample(2'd3, 8'h80);
        start_frame(1'b0, 2'd0, 8'h00);
        run_frame(0);
        start_frame(1'b0, 2'd0, 8'h00);
        run_frame(1);
        start_frame(1'b1, 2'd2, 8'h3C);
        run_frame(2);
        start_frame(1'b0, 2'd0, 8'h00);
        run_frame(3);
        check("ovr sticky", 32'(ovr), 1);
        start_frame(1'b0, 2'd0, 8'h00);
        run_frame(4);

        // Clear and overrun together: set must win; then a lone clear takes effect.
        start_frame(1'b0, 2'd0, 8'h00);
        ovr_clr = 1'b1;
        fs      = 1'b1;
        tick();
        ovr_clr = 1'b0;
        fs      = 1'b0;
        check("clr+fs ovr", 32'(ovr), 1);
        check("clr+fs state", 32'(state), 32'(ST_REQ));
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        check("clr ovr", 32'(ovr), 0);
        bus.se_ack = 1'b1;
        tick();
        bus.se_ack = 1'b0;
        check("g0 pcm_s", 32'(pcm_s), 32'h55);
        tick();
        bus.d_ready = 1'b1;
        tick();
        bus.d_ready = 1'b0;
        check("g1 se_ch", 32'(bus.se_ch), 1);
        bus.se_ack = 1'b1;
        tick();
        bus.se_ack = 1'b0;
        tick();
        check("g1 d_valid", 32'(bus.d_valid), 1);
        check("g1 d_ch", 32'(bus.d_ch), 1);

        // Reset in OUT of ch1 abandons the frame.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_zero("mid reset");
        repeat (3) begin
            tick();
            check("post reset frame_done", 32'(frame_done), 0);
            check("post reset busy", 32'(busy), 0);
        end
        write_sample(2'd0, 8'h11);
        start_frame(1'b0, 2'd0, 8'h00);
        run_frame(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/in_pcm_sched.md
# in_pcm_sched

Channel scheduler that time-multiplexes one IN_PCM datapath (G.711 expand + difference) across NCH voice channels. It double-buffers one 8-bit companded sample per channel per frame, fetches each channel's signal estimate SE from the predictor-state store over a req/ack handshake, and drives S/LAW/SE into IN_PCM. It captures the 16-bit difference D and presents it downstream with a valid/ready handshake, in channel order 0..NCH-1, once per frame strobe.

## Interface
- NCH, 32: channels per frame (2..256)
- CHW, 5: channel index width, clog2(NCH)
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- fs  in  1  frame strobe, 1-cycle pulse
- s_wr_en  in  1  sample write strobe
- s_wr_ch  in  CHW  channel of written sample
- s_wr_data  in  8  companded PCM sample
- law_sel  in  NCH  per-channel law, 0 = A-law, 1 = u-law (static config)
- se_req  out  1  SE fetch request
- se_ch  out  CHW  channel being fetched
- se_ack  in  1  SE data valid
- se_data  in  15  signal estimate
- pcm_s  out  8  to IN_PCM S
- pcm_law  out  1  to IN_PCM LAW
- pcm_se  out  15  to IN_PCM SE
- pcm_d  in  16  from IN_PCM D (combinational return)
- d_valid  out  1  difference valid
- d_ch  out  CHW  channel of d_out
- d_out  out  16  captured difference
- d_ready  in  1  downstream accept
- busy  out  1  frame in progress
- frame_done  out  1  1-cycle pulse after last channel accepted
- ovr  out  1  sticky frame-overrun flag
- ovr_clr  in  1  clears ovr

## Operation
- Sample store: two banks of NCH x 8 bits. Writes go to bank wr_bank; s_wr_ch >= NCH is ignored. On accepted fs, rd_bank <= wr_bank, wr_bank <= ~wr_bank. A write in the same cycle as an accepted fs lands in the pre-swap bank, so it belongs to the frame being started.
- FSM states IDLE, REQ, EXEC, OUT:
- IDLE: busy = 0. fs -> swap banks, ch <= 0, go to REQ.
- REQ: se_req = 1, se_ch = ch. On se_ack, load pcm_se <= se_data, pcm_s <= rd_bank[ch], pcm_law <= law_sel[ch]; go to EXEC.
- EXEC: one cycle. IN_PCM is combinational. d_out <= pcm_d, d_ch <= ch; go to OUT.
- OUT: d_valid = 1. On d_ready, if ch == NCH-1, go to IDLE and pulse frame_done next cycle; else ch <= ch+1 and go to REQ.
- busy = 1 in REQ, EXEC and OUT.
- fs while not IDLE: ignored (no swap, no restart) and ovr <= 1. ovr_clr clears ovr; if set and clear occur in the same cycle, set wins.
- d_out, d_ch and the pcm_* outputs hold their value until the next load. d_out is stable while d_valid = 1.
- No arithmetic on the data path besides the ch increment. Widths pass through unchanged.

## Timing
- Reset: state IDLE, wr_bank = 0, ch = 0, both banks cleared to 8'h00. se_req, se_ch, pcm_s, pcm_law, pcm_se, d_valid, d_ch, d_out, busy, frame_done and ovr are all 0.
- Reset mid-frame abandons the frame with no frame_done. The first fs after reset reads bank 0.
- fs accepted in cycle t: se_req = 1 at t+1.
- se_ack in cycle t: EXEC at t+1, d_valid = 1 at t+2.
- Per channel: minimum 3 cycles (REQ, EXEC, OUT) with se_ack and d_ready held high. Minimum frame is 3*NCH cycles plus 1 IDLE cycle before the next fs is accepted.
- se_ack while se_req = 0 is ignored. d_ready while d_valid = 0 is ignored.
- frame_done is asserted in the IDLE cycle that follows the final OUT handshake. fs in that same cycle is accepted.

## Structure
- Package in_pcm_sched_pkg holds: state enum (IDLE, REQ, EXEC, OUT); width constants S_W = 8, SE_W = 15, D_W = 16; NCH default.
- Sub-module pcm_sample_bank holds the two banks, wr_bank, the swap logic and the read mux; its ports are write port, swap strobe, read channel and read data.
- IN_PCM is instantiated alongside this block by the enclosing channel wrapper, not inside it.

## Test plan
- Reset, then write ch0 = 0xD5 and ch1 = 0xFF, fs, with se_ack/d_ready held 1 (NCH = 2): se_req at +1, d_valid at +3; d_ch sequence 0, 1; d_out equals pcm_d at EXEC; frame_done at +7.
- Double buffering: write ch0 = 0x55 during frame 1 -> frame 1 still uses the old ch0 value; frame 2 uses 0x55. A write in the same cycle as fs appears in that frame.
- Backpressure: hold d_ready = 0 for 10 cycles in OUT -> d_valid, d_out and d_ch stable; no se_req until accept. Delay se_ack by 5 cycles -> se_ch held; no EXEC.
- Overrun: fs during REQ of ch3 -> ovr = 1, channel order unaffected, no bank swap. ovr_clr and fs on the same later busy cycle -> ovr stays 1.
- Law select: law_sel = 'b10, both samples 0x80 -> pcm_law = 0 for ch0, 1 for ch1; pcm_se equals se_data captured on ack.
- Reset asserted during OUT of ch1 -> all outputs 0 next cycle, no frame_done; next fs restarts at ch0 reading bank 0.
